// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR fault injector.
// Holds the replica index constants, the controller state encoding and the
// default data/counter widths used by the interface and the modules.
package tmr_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  localparam logic [1:0] REP_0    = 2'd0;
  localparam logic [1:0] REP_1    = 2'd1;
  localparam logic [1:0] REP_2    = 2'd2;
  localparam logic [1:0] REP_NONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    INJECT = 2'd2
  } state_t;

endpackage

// File: rtl/tmr_fault_injector_if.sv
// Injection command channel of the TMR fault injector.
// master: drives cmd_valid, cmd_rep, cmd_mask, cmd_delay, cmd_dur, abort;
//         receives cmd_ready.
// slave : the injector side (mirror of master).
interface tmr_fault_injector_if
  import tmr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_rep;
  logic [WIDTH-1:0] cmd_mask;
  logic [CNT_W-1:0] cmd_delay;
  logic [CNT_W-1:0] cmd_dur;
  logic             abort;

  modport master (
    output cmd_valid, cmd_rep, cmd_mask, cmd_delay, cmd_dur, abort,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_rep, cmd_mask, cmd_delay, cmd_dur, abort,
    output cmd_ready
  );
endinterface

// File: rtl/tmr_inject_timer.sv
// Loadable down-counter shared by the DELAY and INJECT phases.
// Ports: clk, rst (sync, active high), load/load_val (load has priority),
//        dec (decrement, holds at zero), zero/one (count == 0 / count == 1).
module tmr_inject_timer
  import tmr_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             one
);
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign zero = (cnt_reg == '0);
  assign one  = (cnt_reg == {{(CNT_W-1){1'b0}}, 1'b1});
endmodule

// File: rtl/tmr_fault_injector.sv
// Drives three registered replicas of a clean data word and corrupts one
// selected replica with an XOR mask for a timed window (delay, then duration).
// Ports: clk, rst (sync, active high), din (clean word), cmd (command channel,
//        slave side), rep0..rep2 (replicas), busy (not idle), inj_active
//        (a replica output is corrupted), done (timed injection expired),
//        inj_count (saturating count of corrupted output cycles).
module tmr_fault_injector
  import tmr_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  tmr_fault_injector_if.slave  cmd,
  output logic [WIDTH-1:0]     rep0,
  output logic [WIDTH-1:0]     rep1,
  output logic [WIDTH-1:0]     rep2,
  output logic                 busy,
  output logic                 inj_active,
  output logic                 done,
  output logic [CNT_W-1:0]     inj_count
);
  state_t                 state_reg, state_next;
  logic [1:0]             rep_sel_reg;
  logic [WIDTH-1:0]       mask_reg;
  logic [CNT_W-1:0]       dur_reg;
  logic [2:0][WIDTH-1:0]  rep_reg;
  logic [2:0][WIDTH-1:0]  rep_next;
  logic                   inj_active_reg, inj_active_next;
  logic                   done_reg, done_next;
  logic [CNT_W-1:0]       inj_count_reg;

  logic                   accept;
  logic                   tmr_load, tmr_dec, tmr_zero, tmr_one;
  logic [CNT_W-1:0]       tmr_load_val;

  assign cmd.cmd_ready = (state_reg == IDLE) && !rst && !cmd.abort;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;

  tmr_inject_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero),
    .one      (tmr_one)
  );

  always_comb begin
    state_next   = state_reg;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_dec      = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next   = DELAY;
          tmr_load     = 1'b1;
          tmr_load_val = cmd.cmd_delay;
        end
      end
      DELAY: begin
        if (tmr_zero) begin
          state_next   = INJECT;
          tmr_load     = 1'b1;
          tmr_load_val = dur_reg;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      INJECT: begin
        // A zero duration means a permanent injection that only abort ends.
        if (dur_reg != '0) begin
          if (tmr_one) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort beats both a same-cycle expiry and a same-cycle command.
    if (cmd.abort) begin
      state_next = IDLE;
      done_next  = 1'b0;
      tmr_load   = 1'b0;
      tmr_dec    = 1'b0;
    end
  end

  // Only the replica matching the latched selector sees the mask, so at most
  // one replica differs from the clean word at any time.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_rep
      assign rep_next[gi] = din ^ (((state_reg == INJECT) && (rep_sel_reg == 2'(gi)))
                                   ? mask_reg : '0);
    end
  endgenerate

  assign inj_active_next = (state_reg == INJECT) && (rep_sel_reg != REP_NONE) &&
                           (mask_reg != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      rep_sel_reg    <= REP_0;
      mask_reg       <= '0;
      dur_reg        <= '0;
      rep_reg        <= '0;
      inj_active_reg <= 1'b0;
      done_reg       <= 1'b0;
      inj_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      rep_reg        <= rep_next;
      inj_active_reg <= inj_active_next;
      done_reg       <= done_next;
      if (accept) begin
        rep_sel_reg <= cmd.cmd_rep;
        mask_reg    <= cmd.cmd_mask;
        dur_reg     <= cmd.cmd_dur;
      end
      if (inj_active_next && inj_count_reg != '1) begin
        inj_count_reg <= inj_count_reg + 1'b1;
      end
    end
  end

  assign rep0       = rep_reg[0];
  assign rep1       = rep_reg[1];
  assign rep2       = rep_reg[2];
  assign busy       = (state_reg != IDLE);
  assign inj_active = inj_active_reg;
  assign done       = done_reg;
  assign inj_count  = inj_count_reg;
endmodule

// File: tb/tb_tmr_fault_injector.sv
// Self-checking bench for tmr_fault_injector: a window-based model (each
// accepted command becomes a range of corrupted edges plus a done edge) is
// compared against the DUT on every negative clock edge, alongside literal
// expectations for the directed scenarios.
module tb_tmr_fault_injector;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [7:0]  rep0, rep1, rep2;
  logic        busy, inj_active, done;
  logic [15:0] inj_count;

  tmr_fault_injector_if #(.WIDTH(8), .CNT_W(16)) cif ();

  tmr_fault_injector dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .cmd        (cif.slave),
    .rep0       (rep0),
    .rep1       (rep1),
    .rep2       (rep2),
    .busy       (busy),
    .inj_active (inj_active),
    .done       (done),
    .inj_count  (inj_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checking_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam longint NEVER = 64'h7FFF_FFFF_FFFF_FFFF;
  longint     cyc = 0;
  bit         m_active = 0;
  bit         m_timed = 0;
  logic [1:0] m_rep = 0;
  logic [7:0] m_mask = 0;
  longint     m_first = 0, m_last = 0;
  logic [7:0] e_rep [3];
  logic [7:0] e_clean = 0;
  bit         e_inj = 0, e_done = 0;
  logic [15:0] e_cnt = 0;

  always @(posedge clk) begin
    bit corrupt, was_idle;
    cyc++;
    if (rst) begin
      m_active = 0;
      for (int k = 0; k < 3; k++) e_rep[k] = 8'h00;
      e_clean = 8'h00;
      e_inj = 0; e_done = 0; e_cnt = 0;
    end else begin
      corrupt = m_active && cyc >= m_first && cyc <= m_last;
      for (int k = 0; k < 3; k++)
        e_rep[k] = din ^ ((corrupt && m_rep == 2'(k)) ? m_mask : 8'h00);
      e_clean = din;
      e_inj = corrupt && m_rep != 2'd3 && m_mask != 8'h00;
      if (e_inj && e_cnt != 16'hFFFF) e_cnt++;
      e_done = m_active && m_timed && !cif.abort && cyc == m_last;
      was_idle = !m_active;
      if (cif.abort) m_active = 0;
      else if (m_active && m_timed && cyc == m_last) m_active = 0;
      if (was_idle && cif.cmd_valid && !cif.abort) begin
        m_active = 1;
        m_rep    = cif.cmd_rep;
        m_mask   = cif.cmd_mask;
        m_timed  = (cif.cmd_dur != 16'd0);
        m_first  = cyc + longint'(cif.cmd_delay) + 2;
        m_last   = m_timed ? cyc + longint'(cif.cmd_delay) + 1 + longint'(cif.cmd_dur) : NEVER;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [7:0] vote;
    if (checking_on) begin
      chk("rep0", 32'(rep0), 32'(e_rep[0]));
      chk("rep1", 32'(rep1), 32'(e_rep[1]));
      chk("rep2", 32'(rep2), 32'(e_rep[2]));
      chk("inj_active", 32'(inj_active), 32'(e_inj));
      chk("done", 32'(done), 32'(e_done));
      chk("busy", 32'(busy), 32'(m_active));
      chk("inj_count", 32'(inj_count), 32'(e_cnt));
      chk("cmd_ready", 32'(cif.cmd_ready), 32'(!m_active && !rst && !cif.abort));
      vote = (rep0 & rep1) | (rep0 & rep2) | (rep1 & rep2);
      chk("voter", 32'(vote), 32'(e_clean));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [1:0] r, input logic [7:0] m,
                      input logic [15:0] d, input logic [15:0] u);
    cif.cmd_valid = 1'b1;
    cif.cmd_rep   = r;
    cif.cmd_mask  = m;
    cif.cmd_delay = d;
    cif.cmd_dur   = u;
    $display("cyc=%0d cmd rep=%0d mask=%02h delay=%0d dur=%0d", cyc, r, m, d, u);
  endtask

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_rep   = 2'd0;
    cif.cmd_mask  = 8'h00;
    cif.cmd_delay = 16'd0;
    cif.cmd_dur   = 16'd0;
    cif.abort     = 1'b0;
    din = 8'hA5;

    // 1: reset with din held
    tick(1);
    checking_on = 1'b1;
    rst = 1'b0;
    tick(1);
    chk("reset_rep0", 32'(rep0), 32'h A5);
    chk("reset_rep1", 32'(rep1), 32'h A5);
    chk("reset_rep2", 32'(rep2), 32'h A5);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_count", 32'(inj_count), 32'h0);
    $display("cyc=%0d reset scenario rep=%02h/%02h/%02h", cyc, rep0, rep1, rep2);

    // 2: timed injection on replica 1
    din = 8'h3C;
    tick(1);
    send(2'd1, 8'h0F, 16'd2, 16'd3);
    tick(1);                       // acceptance edge e0
    cif.cmd_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      chk("timed_rep1", 32'(rep1), (i >= 4 && i <= 6) ? 32'h33 : 32'h3C);
      chk("timed_done", 32'(done), (i == 6) ? 32'h1 : 32'h0);
      $display("cyc=%0d timed e0+%0d rep1=%02h done=%0b", cyc, i, rep1, done);
    end
    chk("timed_count", 32'(inj_count), 32'd3);

    // 3: permanent injection on replica 2, aborted after 10 INJECT cycles
    send(2'd2, 8'h80, 16'd0, 16'd0);
    tick(1);                       // e0
    cif.cmd_valid = 1'b0;
    tick(10);
    chk("perm_rep2", 32'(rep2), 32'h BC);
    cif.abort = 1'b1;
    tick(1);                       // abort edge e0+11
    cif.abort = 1'b0;
    chk("perm_busy", 32'(busy), 32'h0);
    chk("perm_count", 32'(inj_count), 32'd13);
    $display("cyc=%0d permanent aborted count=%0d", cyc, inj_count);

    // 4: command held while busy, with varying din
    send(2'd0, 8'h01, 16'd0, 16'd2);
    tick(1);                       // e0
    send(2'd1, 8'h02, 16'd1, 16'd1);
    for (int i = 1; i <= 8; i++) begin
      din = 8'(i * 37 + 5);
      if (i == 3) chk("held_ready_busy", 32'(cif.cmd_ready), 32'h0);
      if (i == 4) chk("held_ready_idle", 32'(cif.cmd_ready), 32'h1);
      tick(1);
      if (i == 4) cif.cmd_valid = 1'b0;
      $display("cyc=%0d held e0+%0d busy=%0b rep1=%02h", cyc, i, busy, rep1);
    end
    chk("held_count", 32'(inj_count), 32'd16);
    din = 8'h5A;
    cif.abort = 1'b1;
    send(2'd0, 8'hFF, 16'd0, 16'd5);
    tick(1);
    cif.abort = 1'b0;
    cif.cmd_valid = 1'b0;
    chk("abort_cmd_busy", 32'(busy), 32'h0);
    tick(2);

    // 5: dry run
    din = 8'h77;
    send(2'd3, 8'hFF, 16'd1, 16'd2);
    tick(1);                       // e0
    cif.cmd_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk("dry_done", 32'(done), (i == 4) ? 32'h1 : 32'h0);
      chk("dry_rep0", 32'(rep0), 32'h77);
    end
    chk("dry_count", 32'(inj_count), 32'd16);
    $display("cyc=%0d dry run count=%0d", cyc, inj_count);

    // 6: reset in the middle of INJECT
    send(2'd0, 8'h55, 16'd0, 16'd5);
    tick(1);
    cif.cmd_valid = 1'b0;
    tick(3);
    chk("midrst_pre_rep0", 32'(rep0), 32'h22);
    rst = 1'b1;
    tick(1);
    chk("midrst_rep0", 32'(rep0), 32'h0);
    chk("midrst_rep1", 32'(rep1), 32'h0);
    chk("midrst_inj", 32'(inj_active), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_count", 32'(inj_count), 32'h0);
    rst = 1'b0;
    tick(8);
    $display("cyc=%0d mid-inject reset done", cyc);

    checking_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
